// File: rtl/alu_cc_unit.sv
// One-stage ALU with a {ZF,SF,OF} condition-code register and valid/ready handshakes.
// Results and flags are registered; in_ready is the only combinational output.
module alu_cc_unit #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_icode,
   input  logic [3:0]       in_ifun,
   input  logic [WIDTH-1:0] in_val_a,
   input  logic [WIDTH-1:0] in_val_b,
   input  logic [WIDTH-1:0] in_val_c,
   input  logic             set_cc_en,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_val_e,
   output logic             out_cnd,
   output logic             out_cf,
   output logic             out_err,
   output logic [2:0]       out_cc
);

   typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_AND = 2'd2, OP_XOR = 2'd3} op_e;

   localparam logic [WIDTH-1:0] STEP     = WIDTH'(WIDTH / 8);
   localparam logic [WIDTH-1:0] NEG_STEP = {WIDTH{1'b0}} - STEP;

   logic             r_valid;
   logic [WIDTH-1:0] r_val_e;
   logic             r_cnd;
   logic             r_cf;
   logic             r_err;
   logic [2:0]       r_cc;

   logic             w_xfer;
   logic             w_is_op;
   logic             w_bad_op;
   logic             w_cc_upd;
   op_e              w_op;
   logic [WIDTH-1:0] w_alu_a;
   logic [WIDTH-1:0] w_alu_b;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH-1:0] w_res;
   logic             w_cf;
   logic             w_of;
   logic             w_cnd;
   logic             w_cnd_err;
   logic             w_zf;
   logic             w_sf;
   logic             w_ovf;

   assign in_ready = (!r_valid || out_ready) && !flush;
   assign w_xfer   = in_valid && in_ready;
   assign w_is_op  = (in_icode == 4'h6);
   assign w_bad_op = w_is_op && (in_ifun > 4'h3);
   assign w_op     = w_is_op ? op_e'(in_ifun[1:0]) : OP_ADD;
   assign w_cc_upd = w_xfer && w_is_op && !w_bad_op && set_cc_en && !flush;
   assign w_sum    = {1'b0, w_alu_b} + {1'b0, w_alu_a};
   assign w_diff   = {1'b0, w_alu_b} - {1'b0, w_alu_a};
   assign w_zf     = r_cc[2];
   assign w_sf     = r_cc[1];
   assign w_ovf    = r_cc[0];

   // Operand selection by instruction code
   always_comb begin
      w_alu_a = {WIDTH{1'b0}};
      w_alu_b = {WIDTH{1'b0}};
      case (in_icode)
         4'h2, 4'h6:       w_alu_a = in_val_a;
         4'h3, 4'h4, 4'h5: w_alu_a = in_val_c;
         4'h9, 4'hB:       w_alu_a = STEP;
         4'h8, 4'hA:       w_alu_a = NEG_STEP;
         default:          w_alu_a = {WIDTH{1'b0}};
      endcase
      case (in_icode)
         4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: w_alu_b = in_val_b;
         default:                                  w_alu_b = {WIDTH{1'b0}};
      endcase
   end

   // Result, carry/borrow and overflow; an illegal OPq function yields zero
   always_comb begin
      w_res = {WIDTH{1'b0}};
      w_cf  = 1'b0;
      w_of  = 1'b0;
      if (w_bad_op) begin
         w_res = {WIDTH{1'b0}};
      end else begin
         case (w_op)
            OP_ADD: begin
               w_res = w_sum[WIDTH-1:0];
               w_cf  = w_sum[WIDTH];
               w_of  = (w_alu_a[WIDTH-1] == w_alu_b[WIDTH-1]) && (w_res[WIDTH-1] != w_alu_a[WIDTH-1]);
            end
            OP_SUB: begin
               w_res = w_diff[WIDTH-1:0];
               w_cf  = w_diff[WIDTH];
               w_of  = (w_alu_a[WIDTH-1] != w_alu_b[WIDTH-1]) && (w_res[WIDTH-1] != w_alu_b[WIDTH-1]);
            end
            OP_AND:  w_res = w_alu_a & w_alu_b;
            OP_XOR:  w_res = w_alu_a ^ w_alu_b;
            default: w_res = {WIDTH{1'b0}};
         endcase
      end
   end

   // Condition evaluation from the CC value held before the accepting edge
   always_comb begin
      w_cnd     = 1'b0;
      w_cnd_err = 1'b0;
      if ((in_icode == 4'h2) || (in_icode == 4'h7)) begin
         case (in_ifun)
            4'h0:    w_cnd = 1'b1;
            4'h1:    w_cnd = (w_sf ^ w_ovf) | w_zf;
            4'h2:    w_cnd = w_sf ^ w_ovf;
            4'h3:    w_cnd = w_zf;
            4'h4:    w_cnd = !w_zf;
            4'h5:    w_cnd = !(w_sf ^ w_ovf);
            4'h6:    w_cnd = !(w_sf ^ w_ovf) && !w_zf;
            default: w_cnd_err = 1'b1;
         endcase
      end else begin
         w_cnd = 1'b0;
      end
   end

   // Output register: flush drops it, a transfer loads it, a drained result clears it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_val_e <= {WIDTH{1'b0}};
         r_cnd   <= 1'b0;
         r_cf    <= 1'b0;
         r_err   <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_xfer) begin
         r_valid <= 1'b1;
         r_val_e <= w_res;
         r_cnd   <= w_cnd;
         r_cf    <= w_cf;
         r_err   <= w_bad_op || w_cnd_err;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   // Condition-code register {ZF,SF,OF}
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cc <= 3'b100;
      end else if (w_cc_upd) begin
         r_cc <= {(w_res == {WIDTH{1'b0}}), w_res[WIDTH-1], w_of};
      end
   end

   assign out_valid = r_valid;
   assign out_val_e = r_val_e;
   assign out_cnd   = r_cnd;
   assign out_cf    = r_cf;
   assign out_err   = r_err;
   assign out_cc    = r_cc;

endmodule

// File: tb/tb_alu_cc_unit.sv
// Directed bench for alu_cc_unit (WIDTH=64): a vector table with a cumulative CC
// expectation, then hand-written back-to-back, stall, flush and reset sequences.
module tb_alu_cc_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_icode = 4'h0;
   logic [3:0]  in_ifun = 4'h0;
   logic [63:0] in_val_a = 64'h0;
   logic [63:0] in_val_b = 64'h0;
   logic [63:0] in_val_c = 64'h0;
   logic        set_cc_en = 1'b1;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_val_e;
   logic        out_cnd;
   logic        out_cf;
   logic        out_err;
   logic [2:0]  out_cc;

   int n_chk = 0;
   int n_err = 0;

   alu_cc_unit #(.WIDTH(64)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_icode(in_icode), .in_ifun(in_ifun), .in_val_a(in_val_a), .in_val_b(in_val_b),
      .in_val_c(in_val_c), .set_cc_en(set_cc_en), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_val_e(out_val_e),
      .out_cnd(out_cnd), .out_cf(out_cf), .out_err(out_err), .out_cc(out_cc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] c;
      logic        en;
      logic [63:0] val;
      logic        cf;
      logic        cnd;
      logic        err;
      logic [2:0]  cc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                               input logic [63:0] b, input logic [63:0] c, input logic en,
                               input logic [63:0] val, input logic cf, input logic cnd,
                               input logic err, input logic [2:0] cc);
      vec_t v;
      v.icode = ic; v.ifun = fn; v.a = a; v.b = b; v.c = c; v.en = en;
      v.val = val; v.cf = cf; v.cnd = cnd; v.err = err; v.cc = cc;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] c, input logic en);
      in_icode = ic; in_ifun = fn; in_val_a = a; in_val_b = b; in_val_c = c; set_cc_en = en;
   endtask

   // OPq accepted at edge N, condition instruction accepted at edge N+1
   task automatic b2b(input string nm, input logic [3:0] fn, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] val1, input logic [2:0] cc1,
                      input logic [3:0] cfn, input logic cnd2);
      @(negedge clk);
      drive(4'h6, fn, a, b, 64'h0, 1'b1);
      in_valid = 1'b1;
      @(posedge clk);
      #1 drive(4'h7, cfn, 64'h0, 64'h0, 64'h0, 1'b1);
      @(negedge clk);
      chk({nm, ".val1"}, out_val_e, val1);
      chk({nm, ".cc1"}, {61'h0, out_cc}, {61'h0, cc1});
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk({nm, ".valid2"}, {63'h0, out_valid}, 64'h1);
      chk({nm, ".cnd2"}, {63'h0, out_cnd}, {63'h0, cnd2});
   endtask

   initial begin
      // icode ifun a b c en | val cf cnd err cc-after
      tbl.push_back(mk(4'h6, 4'h1, 64'h5, 64'h3, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 3'b010));
      tbl.push_back(mk(4'h7, 4'h2, 64'h0, 64'h0, 64'h0, 1'b1, 64'h0, 1'b0, 1'b1, 1'b0, 3'b010));
      tbl.push_back(mk(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1,
                       64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 3'b011));
      tbl.push_back(mk(4'h7, 4'h2, 64'h0, 64'h0, 64'h0, 1'b1, 64'h0, 1'b0, 1'b0, 1'b0, 3'b011));
      tbl.push_back(mk(4'h7, 4'h1, 64'h0, 64'h0, 64'h0, 1'b1, 64'h0, 1'b0, 1'b0, 1'b0, 3'b011));
      tbl.push_back(mk(4'h7, 4'h5, 64'h0, 64'h0, 64'h0, 1'b1, 64'h0, 1'b0, 1'b1, 1'b0, 3'b011));
      tbl.push_back(mk(4'h2, 4'h6, 64'h1234, 64'h99, 64'h0, 1'b1, 64'h1234, 1'b0, 1'b1, 1'b0, 3'b011));
      tbl.push_back(mk(4'hA, 4'h0, 64'h0, 64'h100, 64'h0, 1'b1, 64'hF8, 1'b1, 1'b0, 1'b0, 3'b011));
      tbl.push_back(mk(4'hB, 4'h0, 64'h0, 64'h100, 64'h0, 1'b1, 64'h108, 1'b0, 1'b0, 1'b0, 3'b011));
      tbl.push_back(mk(4'h6, 4'h5, 64'h1, 64'h2, 64'h0, 1'b1, 64'h0, 1'b0, 1'b0, 1'b1, 3'b011));
      tbl.push_back(mk(4'h6, 4'h2, 64'hF0F0, 64'hFF00, 64'h0, 1'b1, 64'hF000, 1'b0, 1'b0, 1'b0, 3'b000));
      tbl.push_back(mk(4'h6, 4'h3, 64'hAAAA, 64'hAAAA, 64'h0, 1'b1, 64'h0, 1'b0, 1'b0, 1'b0, 3'b100));
      tbl.push_back(mk(4'h7, 4'h3, 64'h0, 64'h0, 64'h0, 1'b1, 64'h0, 1'b0, 1'b1, 1'b0, 3'b100));
      tbl.push_back(mk(4'h7, 4'h4, 64'h0, 64'h0, 64'h0, 1'b1, 64'h0, 1'b0, 1'b0, 1'b0, 3'b100));
      tbl.push_back(mk(4'h7, 4'h7, 64'h0, 64'h0, 64'h0, 1'b1, 64'h0, 1'b0, 1'b0, 1'b1, 3'b100));
      tbl.push_back(mk(4'h6, 4'h0, 64'h1, 64'h1, 64'h0, 1'b0, 64'h2, 1'b0, 1'b0, 1'b0, 3'b100));
      tbl.push_back(mk(4'h6, 4'h1, 64'h8000_0000_0000_0000, 64'h0, 64'h0, 1'b1,
                       64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 3'b011));
      tbl.push_back(mk(4'h4, 4'h0, 64'h5, 64'h20, 64'h10, 1'b1, 64'h30, 1'b0, 1'b0, 1'b0, 3'b011));
      tbl.push_back(mk(4'h3, 4'h0, 64'h5, 64'h20, 64'hDEAD, 1'b1, 64'hDEAD, 1'b0, 1'b0, 1'b0, 3'b011));
      tbl.push_back(mk(4'h8, 4'h0, 64'h0, 64'h10, 64'h0, 1'b1, 64'h8, 1'b1, 1'b0, 1'b0, 3'b011));
      tbl.push_back(mk(4'h9, 4'h0, 64'h0, 64'h0, 64'h0, 1'b1, 64'h8, 1'b0, 1'b0, 1'b0, 3'b011));
      tbl.push_back(mk(4'h1, 4'h0, 64'h77, 64'h88, 64'h99, 1'b1, 64'h0, 1'b0, 1'b0, 1'b0, 3'b011));
      tbl.push_back(mk(4'h6, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'h0, 1'b1, 64'h1, 1'b1, 1'b0, 1'b0, 3'b000));

      #2 rst_n = 1'b0;
      #10;
      chk("rst.valid", {63'h0, out_valid}, 64'h0);
      chk("rst.val", out_val_e, 64'h0);
      chk("rst.flags", {61'h0, out_cnd, out_cf, out_err}, 64'h0);
      chk("rst.cc", {61'h0, out_cc}, 64'h4);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst.in_ready", {63'h0, in_ready}, 64'h1);

      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i].icode, tbl[i].ifun, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].en);
         in_valid = 1'b1;
         @(posedge clk);
         #1 in_valid = 1'b0;
         @(negedge clk);
         chk($sformatf("v%0d.valid", i), {63'h0, out_valid}, 64'h1);
         chk($sformatf("v%0d.val", i), out_val_e, tbl[i].val);
         chk($sformatf("v%0d.cf", i), {63'h0, out_cf}, {63'h0, tbl[i].cf});
         chk($sformatf("v%0d.cnd", i), {63'h0, out_cnd}, {63'h0, tbl[i].cnd});
         chk($sformatf("v%0d.err", i), {63'h0, out_err}, {63'h0, tbl[i].err});
         chk($sformatf("v%0d.cc", i), {61'h0, out_cc}, {61'h0, tbl[i].cc});
      end

      // CC is 000 here
      b2b("b2b_of", 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_FFFF_FFFE, 3'b011, 4'h2, 1'b0);
      b2b("b2b_zf", 4'h1, 64'h5, 64'h5, 64'h0, 3'b100, 4'h3, 1'b1);

      // Stall: first result held three cycles while a second input waits
      @(negedge clk);
      out_ready = 1'b0;
      drive(4'h6, 4'h0, 64'h1, 64'h2, 64'h0, 1'b1);
      in_valid = 1'b1;
      @(posedge clk);
      #1 drive(4'h6, 4'h0, 64'h3, 64'h4, 64'h0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("stall%0d.in_ready", k), {63'h0, in_ready}, 64'h0);
         chk($sformatf("stall%0d.valid", k), {63'h0, out_valid}, 64'h1);
         chk($sformatf("stall%0d.val", k), out_val_e, 64'h3);
      end
      out_ready = 1'b1;
      #1 chk("stall.release_ready", {63'h0, in_ready}, 64'h1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("stall.second_val", out_val_e, 64'h7);
      chk("stall.second_cc", {61'h0, out_cc}, 64'h0);

      // Flush: held result is dropped and the offered OPq leaves CC alone
      @(negedge clk);
      out_ready = 1'b0;
      drive(4'h6, 4'h0, 64'h1, 64'h2, 64'h0, 1'b1);
      in_valid = 1'b1;
      @(posedge clk);
      #1 drive(4'h6, 4'h1, 64'h1, 64'h1, 64'h0, 1'b1);
      flush = 1'b1;
      out_ready = 1'b1;
      #1 chk("flush.in_ready", {63'h0, in_ready}, 64'h0);
      @(posedge clk);
      #1 flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush.valid", {63'h0, out_valid}, 64'h0);
      chk("flush.cc", {61'h0, out_cc}, 64'h0);

      // Reset while a result with cc=011 is held
      @(negedge clk);
      out_ready = 1'b0;
      drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("prerst.valid", {63'h0, out_valid}, 64'h1);
      chk("prerst.cc", {61'h0, out_cc}, 64'h3);
      rst_n = 1'b0;
      #1;
      chk("midrst.valid", {63'h0, out_valid}, 64'h0);
      chk("midrst.cc", {61'h0, out_cc}, 64'h4);
      chk("midrst.val", out_val_e, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      drive(4'h7, 4'h3, 64'h0, 64'h0, 64'h0, 1'b1);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("postrst.valid", {63'h0, out_valid}, 64'h1);
      chk("postrst.cnd", {63'h0, out_cnd}, 64'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/alu_cc_unit.md
ALU_CC_UNIT -- requirements
Module: alu_cc_unit

Interface
REQ-001 Parameter WIDTH, default 64: datapath width in bits; legal values 16, 32, 64.
REQ-002 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-004 Port in_valid / in_ready  input / output  1 / 1: upstream handshake; a transfer occurs when both are high at a rising edge.
REQ-005 Port in_icode  input  4 and in_ifun  input  4: instruction code and function.
REQ-006 Ports in_val_a, in_val_b, in_val_c  input  WIDTH each: register operands A and B, and the immediate.
REQ-007 Port set_cc_en  input  1: when low, an accepted OPq does not update CC.
REQ-008 Port flush  input  1: synchronous pipeline flush.
REQ-009 Port out_valid / out_ready  output / input  1 / 1: downstream handshake.
REQ-010 Port out_val_e  output  WIDTH: registered ALU result.
REQ-011 Ports out_cnd, out_cf, out_err  output  1 each: condition outcome, carry/borrow out, illegal-function flag.
REQ-012 Port out_cc  output  3: current CC register {ZF,SF,OF}.

Function
REQ-013 Latency SHALL be exactly one cycle, accepted input to out_valid, through a single output register.
REQ-014 in_ready SHALL equal (!out_valid || out_ready) && !flush.
- Output register loads on each transfer.
- out_valid clears when out_ready is high and there is no transfer.
REQ-015 aluA SHALL be selected by in_icode:
- 2, 6 -> val_a
- 3, 4, 5 -> val_c
- 9, B -> +WIDTH/8
- 8, A -> -(WIDTH/8), two's complement
- all others -> 0
REQ-016 aluB SHALL be selected by in_icode:
- 2, 3 -> 0
- 4, 5, 6, 8, 9, A, B -> val_b
- all others -> 0
REQ-017 For icode 6, the operation SHALL be chosen by ifun: 0 add aluB+aluA, 1 sub aluB-aluA, 2 and, 3 xor. All other icodes SHALL use add.
REQ-018 Arithmetic SHALL be modulo 2^WIDTH.
- out_cf is the carry out of add, or the borrow of sub (1 when aluB<aluA unsigned).
- out_cf is 0 for and/xor.
REQ-019 icode 6 with ifun>3 SHALL set out_err=1 and out_val_e=0, and SHALL leave CC unchanged.
REQ-020 Flag definitions:
- ZF = (result==0).
- SF = result[WIDTH-1].
- OF for add = operands share a sign and the result sign differs.
- OF for sub = the signs of aluB and aluA differ and the result sign differs from aluB.
- OF for and/xor = 0.
REQ-021 CC SHALL update on the same edge as the transfer, only when icode==6, ifun<=3, set_cc_en=1 and flush=0.
REQ-022 out_cnd SHALL be evaluated, for icode 2 or 7 only, from the CC register value before the accepting edge:
- ifun 0: 1
- 1: (SF^OF)|ZF
- 2: SF^OF
- 3: ZF
- 4: !ZF
- 5: !(SF^OF)
- 6: !(SF^OF)&!ZF
REQ-023 For icode 2 or 7 with ifun>6, out_cnd SHALL be 0 and out_err SHALL be 1. For all other icodes, out_cnd SHALL be 0.
REQ-024 Back-to-back operation: an OPq accepted at edge N SHALL be visible in CC to the instruction accepted at edge N+1.
REQ-025 flush=1 at a rising edge SHALL clear out_valid, block any transfer, and suppress the CC update. Flush overrides the handshake.
REQ-026 While out_valid=1 and out_ready=0, all outputs SHALL hold stable.

Reset
REQ-027 On rst_n low, asynchronously:
- out_valid=0, out_val_e=0, out_cnd=0, out_cf=0, out_err=0
- CC={ZF=1,SF=0,OF=0}
REQ-028 Reset asserted mid-operation SHALL discard the held result; the first transfer after rst_n rises SHALL behave as from reset.

Verification
REQ-029 WIDTH=64, icode6/ifun1, val_a=5, val_b=3 -> after one cycle val_e=0xFFFF_FFFF_FFFF_FFFE, cc={0,1,0}, cf=1.
REQ-030 icode6/ifun0, val_a=val_b=0x7FFF_FFFF_FFFF_FFFF, then icode7/ifun2 on the next cycle -> first val_e=0xFFFF_FFFF_FFFF_FFFE with cc={0,1,1}; second out_cnd=0 (SF^OF=0).
REQ-031 icode A, val_b=0x100 -> val_e=0xF8; icode B, val_b=0x100 -> val_e=0x108; cc unchanged both times.
REQ-032 OPq held with out_ready=0 for 3 cycles while a second input is offered -> in_ready=0, val_e stable, second input accepted only on the cycle out_ready rises.
REQ-033 icode6/ifun5 -> out_err=1, val_e=0, cc unchanged. Separately, OPq with set_cc_en=0 or flush=1 -> cc unchanged; flush also drops out_valid.
REQ-034 Assert rst_n low while out_valid=1 holding cc={0,1,1} -> immediately out_valid=0, cc={1,0,0}.
